// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
// States plus the dark-output constants for anode and decimal point.
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP
    } state_e;

    localparam int MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;
    localparam logic DP_OFF = 1'b1;

endpackage

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of a common-anode 7-segment bank.
// New words are double-buffered and swapped in only at frame boundaries.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS  = 8,
    parameter int CLK_DIV = 100000,
    parameter int GAP     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [DIGITS-1:0]     an,
    output logic [3:0]            num,
    output logic                  dp
);

    localparam int CMAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int CW   = $clog2((CMAX > 2) ? CMAX : 2);
    localparam int IW   = $clog2((DIGITS > 2) ? DIGITS : 2);

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_DARK = AN_OFF[DIGITS-1:0];

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic [4*DIGITS-1:0] pend_word_q, pend_word_d;
    logic                pend_q, pend_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          num_q, num_d;
    logic                dp_q, dp_d;
    logic                xfer;
    logic                step_digit;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        pend_word_d = pend_word_q;
        pend_d      = pend_q;
        step_digit  = 1'b0;
        xfer        = data_valid && !pend_q;

        // While idle nothing is on screen, so a word can go live at once.
        if (xfer) begin
            if (state_q == ST_IDLE) begin
                active_d = data_in;
            end else begin
                pend_word_d = data_in;
                pend_d      = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_DRIVE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (GAP == 0) begin
                        step_digit = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d      = '0;
                    state_d    = ST_DRIVE;
                    step_digit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (step_digit) begin
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                if (pend_q) begin
                    active_d = pend_word_q;
                    pend_d   = 1'b0;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Outputs are computed from next state so they register in step.
        an_d  = AN_DARK;
        num_d = '0;
        dp_d  = DP_OFF;
        unique case (state_d)
            ST_DRIVE: begin
                an_d  = blank_mask[idx_d] ? AN_DARK
                                          : ~(DIGITS'(1) << idx_d);
                num_d = active_d[4*idx_d +: 4];
                dp_d  = ~dp_mask[idx_d];
            end
            ST_GAP: begin
                num_d = num_q;
            end
            default: begin
                num_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            active_q    <= '0;
            pend_word_q <= '0;
            pend_q      <= 1'b0;
            an_q        <= AN_DARK;
            num_q       <= '0;
            dp_q        <= DP_OFF;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            pend_word_q <= pend_word_d;
            pend_q      <= pend_d;
            an_q        <= an_d;
            num_q       <= num_d;
            dp_q        <= dp_d;
        end
    end

    assign data_ready = ~pend_q;
    assign an         = an_q;
    assign num        = num_q;
    assign dp         = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: GAP=1 main instance, GAP=0 variant.
// Expected outputs are queued with a cycle stamp and checked at negedge.
module tb_seg_scan_ctrl;

    localparam int DIGITS  = 8;
    localparam int CLK_DIV = 4;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [3:0] num;
        logic       dp;
        logic       rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] data_in;
    logic        data_valid;
    logic [7:0]  blank_mask;
    logic [7:0]  dp_mask;

    logic       rdy1, rdy0;
    logic [7:0] an1, an0;
    logic [3:0] num1, num0;
    logic       dp1, dp0;

    exp_t q1[$];
    exp_t q0[$];
    exp_t me;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    seg_scan_ctrl #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .GAP(1)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy1), .blank_mask(blank_mask),
        .dp_mask(dp_mask), .an(an1), .num(num1), .dp(dp1)
    );

    seg_scan_ctrl #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .GAP(0)
    ) u_dut_g0 (
        .clk(clk), .rst(rst), .enable(enable),
        .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy0), .blank_mask(blank_mask),
        .dp_mask(dp_mask), .an(an0), .num(num0), .dp(dp0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic cmp(input string nm, input int sel,
                       input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h",
                     nm, sel, cyc, act, req);
        end
    endtask

    task automatic chk(input int sel, input exp_t e);
        n_chk++;
        if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL stamp dut%0d: at cyc %0d expected cyc %0d",
                     sel, cyc, e.cyc);
        end
        if (sel == 1) begin
            cmp("an", 1, an1, e.an);
            cmp("num", 1, {4'h0, num1}, {4'h0, e.num});
            cmp("dp", 1, {7'h0, dp1}, {7'h0, e.dp});
            cmp("ready", 1, {7'h0, rdy1}, {7'h0, e.rdy});
        end else begin
            cmp("an", 0, an0, e.an);
            cmp("num", 0, {4'h0, num0}, {4'h0, e.num});
            cmp("dp", 0, {7'h0, dp0}, {7'h0, e.dp});
            cmp("ready", 0, {7'h0, rdy0}, {7'h0, e.rdy});
        end
    endtask

    always @(negedge clk) begin
        while (q1.size() > 0 && q1[0].cyc <= cyc) begin
            me = q1.pop_front();
            chk(1, me);
        end
        while (q0.size() > 0 && q0[0].cyc <= cyc) begin
            me = q0.pop_front();
            chk(0, me);
        end
    end

    task automatic push(input int sel, input int c,
                        input logic [7:0] a, input logic [3:0] n,
                        input logic d, input logic r);
        exp_t e;
        e.cyc = c; e.an = a; e.num = n; e.dp = d; e.rdy = r;
        if (sel == 1) q1.push_back(e);
        else q0.push_back(e);
    endtask

    // Expected scan of one frame: n entries from base, ready low from rlo.
    task automatic push_frame(input int sel, input int base,
                              input logic [31:0] w, input logic [7:0] bl,
                              input logic [7:0] dm, input int rlo,
                              input int n, input int gap);
        int i = 0;
        logic [7:0] a;
        logic [3:0] nib;
        for (int d = 0; d < DIGITS; d++) begin
            nib = w[4*d +: 4];
            a = bl[d] ? 8'hFF : ~(8'h01 << d);
            for (int c = 0; c < CLK_DIV; c++) begin
                if (i < n) push(sel, base + i, a, nib, ~dm[d], i < rlo);
                i++;
            end
            for (int g = 0; g < gap; g++) begin
                if (i < n) push(sel, base + i, 8'hFF, nib, 1'b1, i < rlo);
                i++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: cyc %0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, b5, b6, b7;
        rst = 1'b1; enable = 1'b0; data_in = '0; data_valid = 1'b0;
        blank_mask = '0; dp_mask = '0;
        step();
        push(1, cyc + 1, 8'hFF, 4'h0, 1'b1, 1'b1);
        push(0, cyc + 1, 8'hFF, 4'h0, 1'b1, 1'b1);
        step();
        rst = 1'b0;
        data_valid = 1'b1; data_in = 32'h89ABCDEF;
        push(1, cyc + 1, 8'hFF, 4'h0, 1'b1, 1'b1);
        push(0, cyc + 1, 8'hFF, 4'h0, 1'b1, 1'b1);
        step();
        data_valid = 1'b0; enable = 1'b1;
        b = cyc + 1;
        push_frame(1, b, 32'h89ABCDEF, 8'h00, 8'h00, 1000, 40, 1);
        push_frame(1, b + 40, 32'h89ABCDEF, 8'h00, 8'h00, 10, 40, 1);
        push_frame(0, b, 32'h89ABCDEF, 8'h00, 8'h00, 1000, 32, 0);
        push_frame(0, b + 32, 32'h89ABCDEF, 8'h00, 8'h00, 1000, 1, 0);
        wait_until(b + 49);
        data_valid = 1'b1; data_in = 32'h12345678;
        step();
        data_valid = 1'b0; data_in = '0;
        push_frame(1, b + 80, 32'h12345678, 8'h00, 8'h00, 1000, 40, 1);
        wait_until(b + 119);
        blank_mask = 8'h0F; dp_mask = 8'h80;
        push_frame(1, b + 120, 32'h12345678, 8'h0F, 8'h80, 1000, 40, 1);
        wait_until(b + 159);
        blank_mask = 8'h00; dp_mask = 8'h00;
        b5 = b + 160;
        push_frame(1, b5, 32'h12345678, 8'h00, 8'h00, 1000, 27, 1);
        wait_until(b5 + 26);
        enable = 1'b0;
        push(1, b5 + 27, 8'hFF, 4'h0, 1'b1, 1'b1);
        push(1, b5 + 28, 8'hFF, 4'h0, 1'b1, 1'b1);
        wait_until(b5 + 28);
        enable = 1'b1;
        b6 = b5 + 29;
        push_frame(1, b6, 32'h12345678, 8'h00, 8'h00, 2, 5, 1);
        wait_until(b6 + 1);
        data_valid = 1'b1; data_in = 32'hAAAA5555;
        step();
        data_valid = 1'b0; data_in = '0;
        wait_until(b6 + 4);
        rst = 1'b1;
        push(1, b6 + 5, 8'hFF, 4'h0, 1'b1, 1'b1);
        step();
        rst = 1'b0;
        b7 = b6 + 6;
        push_frame(1, b7, 32'h0, 8'h00, 8'h00, 1000, 40, 1);
        push_frame(1, b7 + 40, 32'h0, 8'h00, 8'h00, 1000, 1, 1);
        wait_until(b7 + 42);
        enable = 1'b0;
        step();
        step();
        cmp("q1_drained", 1, 8'(q1.size()), 8'd0);
        cmp("q0_drained", 0, 8'(q0.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
